// File: rtl/regfile_2r1w.sv
// Parametrised register file with one write port, two registered read ports,
// write-to-read bypass, per-entry valid bits and a synchronous bulk clear.
module regfile_2r1w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             ren_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b,
    output logic [DEPTH-1:0] vmask
);

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    genvar gi;

    // Out-of-range write addresses match no entry, so they are dropped for free.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (wen && waddr == IDX) begin
                    data_reg  <= wdata;
                    valid_reg <= 1'b1;
                end
            end

            assign mem[gi]   = data_reg;
            assign valid[gi] = valid_reg;
        end
    endgenerate

    assign vmask = valid;

    logic [1:0]       ren_v;
    logic [AW-1:0]    raddr_v  [2];
    logic [WIDTH-1:0] rdata_v  [2];
    logic             rvalid_v [2];

    assign ren_v      = {ren_b, ren_a};
    assign raddr_v[0] = raddr_a;
    assign raddr_v[1] = raddr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : gen_port
            logic             in_range;
            logic [WIDTH-1:0] rdata_reg;
            logic [WIDTH-1:0] rdata_next;
            logic             rvalid_reg;
            logic             rvalid_next;

            assign in_range = {1'b0, raddr_v[gi]} < LIMIT;

            // Clear beats bypass; invalid or out-of-range entries read as zero.
            always_comb begin
                rdata_next  = rdata_reg;
                rvalid_next = rvalid_reg;
                if (ren_v[gi]) begin
                    rdata_next  = '0;
                    rvalid_next = 1'b0;
                    if (!clr && in_range) begin
                        if (wen && waddr == raddr_v[gi]) begin
                            rdata_next  = wdata;
                            rvalid_next = 1'b1;
                        end else if (valid[raddr_v[gi]]) begin
                            rdata_next  = mem[raddr_v[gi]];
                            rvalid_next = 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rdata_reg  <= rdata_next;
                    rvalid_reg <= rvalid_next;
                end
            end

            assign rdata_v[gi]  = rdata_reg;
            assign rvalid_v[gi] = rvalid_reg;
        end
    endgenerate

    assign rdata_a  = rdata_v[0];
    assign rvalid_a = rvalid_v[0];
    assign rdata_b  = rdata_v[1];
    assign rvalid_b = rvalid_v[1];

endmodule
